// File: rtl/rv64g_l1_vlsu_lookup_pipe_pkg.sv
// Shared encodings and default geometry for the VLSU registered lookup pipe.
// Coherence states, acquire grow codes and FSM state encodings live here.
package rv64g_l1_vlsu_lookup_pipe_pkg;

  localparam int NUM_LANES = 8;
  localparam int NUM_BANKS = 8;
  localparam int WAYS      = 8;
  localparam int INDEX_W   = 5;
  localparam int OFF_W     = 6;

  localparam logic [1:0] MESI_N  = 2'd0;
  localparam logic [1:0] MESI_B  = 2'd1;
  localparam logic [1:0] MESI_T  = 2'd2;
  localparam logic [1:0] MESI_TT = 2'd3;

  localparam logic [1:0] GROW_NTOB = 2'd0;
  localparam logic [1:0] GROW_NTOT = 2'd1;
  localparam logic [1:0] GROW_BTOT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rv64g_l1_vlsu_lane_lookup.sv
// Single-lane lookup: bank select, tag compare across ways, lowest-way
// priority and load/store permission check. Purely combinational.
module rv64g_l1_vlsu_lane_lookup
  import rv64g_l1_vlsu_lookup_pipe_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int WAYS      = 8,
  parameter int TAG_W     = 53,
  parameter int BANK_W    = 3,
  parameter int WAY_W     = 3
) (
  input  logic                          valid,
  input  logic                          store,
  input  logic [TAG_W-1:0]              tag,
  input  logic [BANK_W-1:0]             bank,
  input  logic [NUM_BANKS*WAYS*TAG_W-1:0] bank_tag_way,
  input  logic [NUM_BANKS*WAYS*2-1:0]   bank_state_way,
  output logic                          hit,
  output logic [WAY_W-1:0]              way,
  output logic [1:0]                    state,
  output logic                          miss,
  output logic                          upgrade
);

  logic             match;
  logic [WAY_W-1:0] match_way;
  logic [1:0]       match_state;
  logic [TAG_W-1:0] way_tag;
  logic [1:0]       way_state;

  always_comb begin
    match       = 1'b0;
    match_way   = '0;
    match_state = MESI_N;
    way_tag     = '0;
    way_state   = MESI_N;
    // Walk from the top way down so the lowest matching way is the last writer.
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_tag   = bank_tag_way[(int'(bank) * WAYS + w) * TAG_W +: TAG_W];
      way_state = bank_state_way[(int'(bank) * WAYS + w) * 2 +: 2];
      if (way_tag == tag && way_state != MESI_N) begin
        match       = 1'b1;
        match_way   = WAY_W'(w);
        match_state = way_state;
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    miss    = 1'b0;
    upgrade = 1'b0;
    way     = '0;
    state   = MESI_N;
    if (valid) begin
      way     = match_way;
      state   = match_state;
      hit     = match && (!store || match_state == MESI_T || match_state == MESI_TT);
      upgrade = match && store && match_state == MESI_B;
      miss    = !hit;
    end
  end

endmodule

// File: rtl/rv64g_l1_vlsu_lookup_pipe.sv
// Registered VLSU lookup: captures one vector op plus the tag/state arrays,
// reports per-lane results one cycle later, then drains line-coalesced misses.
module rv64g_l1_vlsu_lookup_pipe
  import rv64g_l1_vlsu_lookup_pipe_pkg::*;
#(
  parameter int NUM_LANES = rv64g_l1_vlsu_lookup_pipe_pkg::NUM_LANES,
  parameter int NUM_BANKS = rv64g_l1_vlsu_lookup_pipe_pkg::NUM_BANKS,
  parameter int WAYS      = rv64g_l1_vlsu_lookup_pipe_pkg::WAYS,
  parameter int INDEX_W   = rv64g_l1_vlsu_lookup_pipe_pkg::INDEX_W,
  parameter int OFF_W     = rv64g_l1_vlsu_lookup_pipe_pkg::OFF_W,
  localparam int TAG_W    = 64 - INDEX_W - OFF_W,
  localparam int WAY_W    = $clog2(WAYS),
  localparam int BANK_W   = OFF_W - 3,
  localparam int LINE_W   = 64 - OFF_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [NUM_LANES*64-1:0]         lane_addr_i,
  input  logic [NUM_LANES-1:0]            lane_valid_i,
  input  logic [NUM_LANES-1:0]            lane_store_i,
  input  logic [NUM_BANKS*WAYS*TAG_W-1:0] bank_tag_way_i,
  input  logic [NUM_BANKS*WAYS*2-1:0]     bank_state_way_i,
  output logic                            rsp_valid_o,
  output logic [NUM_LANES-1:0]            lane_hit_o,
  output logic [NUM_LANES*WAY_W-1:0]      lane_hit_way_o,
  output logic [NUM_LANES*2-1:0]          lane_state_o,
  output logic [NUM_LANES-1:0]            lane_miss_o,
  output logic [NUM_LANES-1:0]            lane_upgrade_o,
  output logic                            miss_valid_o,
  input  logic                            miss_ready_i,
  output logic [63:0]                     miss_addr_o,
  output logic [1:0]                      miss_grow_o,
  output logic [NUM_LANES-1:0]            miss_lane_mask_o,
  output logic                            busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and DRAIN holds its request stable until taken.

  state_t state_q, state_d;

  logic [63:3]                     addr_q [NUM_LANES];
  logic [NUM_LANES-1:0]            valid_q, store_q, pending_q, upgrade_q;
  logic [NUM_BANKS*WAYS*TAG_W-1:0] tags_q;
  logic [NUM_BANKS*WAYS*2-1:0]     states_q;

  logic [NUM_LANES-1:0]         hit, miss, upgrade, group, pending_left;
  logic [NUM_LANES*WAY_W-1:0]   hit_way;
  logic [NUM_LANES*2-1:0]       hit_state;
  logic [NUM_LANES*3-1:0]       addr_lo;
  logic [LINE_W-1:0]            leader_line;
  logic                         leader_found, accept, lookup, drain, miss_fire;
  logic                         unused_addr_lo;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rv64g_l1_vlsu_lane_lookup #(
      .NUM_BANKS (NUM_BANKS),
      .WAYS      (WAYS),
      .TAG_W     (TAG_W),
      .BANK_W    (BANK_W),
      .WAY_W     (WAY_W)
    ) u_lookup (
      .valid          (valid_q[i]),
      .store          (store_q[i]),
      .tag            (addr_q[i][63:OFF_W+INDEX_W]),
      .bank           (addr_q[i][OFF_W-1:3]),
      .bank_tag_way   (tags_q),
      .bank_state_way (states_q),
      .hit            (hit[i]),
      .way            (hit_way[i*WAY_W +: WAY_W]),
      .state          (hit_state[i*2 +: 2]),
      .miss           (miss[i]),
      .upgrade        (upgrade[i])
    );
    assign addr_lo[i*3 +: 3] = lane_addr_i[i*64 +: 3];
  end

  // Byte-within-bank bits never affect the lookup.
  assign unused_addr_lo = ^addr_lo;

  assign lookup      = (state_q == ST_LOOKUP);
  assign drain       = (state_q == ST_DRAIN);
  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign miss_fire   = miss_valid_o && miss_ready_i;

  // Leader is the lowest pending lane; its line gathers every pending lane on it.
  always_comb begin
    leader_found = 1'b0;
    leader_line  = '0;
    group        = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!leader_found && pending_q[i]) begin
        leader_found = 1'b1;
        leader_line  = addr_q[i][63:OFF_W];
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      group[i] = pending_q[i] && (addr_q[i][63:OFF_W] == leader_line);
    end
    pending_left = pending_q & ~group;
  end

  always_comb begin
    rsp_valid_o      = lookup;
    lane_hit_o       = lookup ? hit : '0;
    lane_hit_way_o   = lookup ? hit_way : '0;
    lane_state_o     = lookup ? hit_state : '0;
    lane_miss_o      = lookup ? miss : '0;
    lane_upgrade_o   = lookup ? upgrade : '0;
    miss_valid_o     = drain;
    miss_addr_o      = drain ? {leader_line, {OFF_W{1'b0}}} : '0;
    miss_lane_mask_o = drain ? group : '0;
    miss_grow_o      = GROW_NTOB;
    if (drain && |(group & store_q)) begin
      miss_grow_o = |(group & upgrade_q) ? GROW_BTOT : GROW_NTOT;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = |miss ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (miss_fire && pending_left == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      store_q   <= '0;
      pending_q <= '0;
      upgrade_q <= '0;
      tags_q    <= '0;
      states_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) addr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        valid_q  <= lane_valid_i;
        store_q  <= lane_store_i;
        tags_q   <= bank_tag_way_i;
        states_q <= bank_state_way_i;
        for (int i = 0; i < NUM_LANES; i++) addr_q[i] <= lane_addr_i[i*64+3 +: 61];
      end
      if (lookup) begin
        pending_q <= miss;
        upgrade_q <= upgrade;
      end else if (miss_fire) begin
        pending_q <= pending_left;
      end
    end
  end

endmodule

// File: tb/tb_rv64g_l1_vlsu_lookup_pipe.sv
// Bench for the VLSU lookup pipe: directed scenarios plus random ops checked
// against a lane-by-lane reference model and an ordered acquire-request queue.
module tb_rv64g_l1_vlsu_lookup_pipe;

  localparam int NL = 8;
  localparam int NB = 8;
  localparam int NW = 8;
  localparam int TW = 53;

  localparam logic [1:0] ST_N = 2'd0, ST_B = 2'd1, ST_T = 2'd2, ST_TT = 2'd3;
  localparam logic [1:0] G_NTOB = 2'd0, G_NTOT = 2'd1, G_BTOT = 2'd2;

  logic                clk, rst_n;
  logic                req_valid, req_ready;
  logic [NL*64-1:0]    lane_addr;
  logic [NL-1:0]       lane_valid, lane_store;
  logic [NB*NW*TW-1:0] bank_tag_way;
  logic [NB*NW*2-1:0]  bank_state_way;
  logic                rsp_valid;
  logic [NL-1:0]       lane_hit, lane_miss, lane_upgrade, miss_lane_mask;
  logic [NL*3-1:0]     lane_hit_way;
  logic [NL*2-1:0]     lane_state;
  logic                miss_valid, miss_ready, busy;
  logic [63:0]         miss_addr;
  logic [1:0]          miss_grow;

  rv64g_l1_vlsu_lookup_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .lane_addr_i      (lane_addr),
    .lane_valid_i     (lane_valid),
    .lane_store_i     (lane_store),
    .bank_tag_way_i   (bank_tag_way),
    .bank_state_way_i (bank_state_way),
    .rsp_valid_o      (rsp_valid),
    .lane_hit_o       (lane_hit),
    .lane_hit_way_o   (lane_hit_way),
    .lane_state_o     (lane_state),
    .lane_miss_o      (lane_miss),
    .lane_upgrade_o   (lane_upgrade),
    .miss_valid_o     (miss_valid),
    .miss_ready_i     (miss_ready),
    .miss_addr_o      (miss_addr),
    .miss_grow_o      (miss_grow),
    .miss_lane_mask_o (miss_lane_mask),
    .busy_o           (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Op under test and cache contents as the bench sees them
  logic [63:0]   addr [NL];
  logic [NL-1:0] vmask, smask;
  logic [TW-1:0] tg [NB][NW];
  logic [1:0]    st [NB][NW];
  int            force_stall = -1;

  // Scoreboard
  logic [NL-1:0]   exp_hit, exp_miss, exp_upg;
  logic [NL*3-1:0] exp_way_bus;
  logic [NL*2-1:0] exp_state_bus;
  logic [63:0]     exp_q [$];
  logic [NL-1:0]   exp_mask_q [$];
  logic [1:0]      exp_grow_q [$];
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-lane lookup, then misses grouped by line in order of first lane.
  task automatic model_op();
    logic [57:0] lines [$];
    logic [NL-1:0] masks [$];
    logic [TW-1:0] t;
    logic [1:0] s;
    int b, idx, wsel;
    bit found;
    exp_hit = '0; exp_miss = '0; exp_upg = '0;
    exp_way_bus = '0; exp_state_bus = '0;
    for (int i = 0; i < NL; i++) begin
      if (vmask[i]) begin
        b = int'(addr[i][5:3]);
        t = addr[i][63:11];
        found = 0; wsel = 0; s = ST_N;
        for (int w = 0; w < NW; w++) begin
          if (!found && tg[b][w] == t && st[b][w] != ST_N) begin
            found = 1; wsel = w; s = st[b][w];
          end
        end
        if (found) begin
          exp_way_bus[i*3 +: 3]   = 3'(wsel);
          exp_state_bus[i*2 +: 2] = s;
        end
        exp_hit[i]  = found && (!smask[i] || s == ST_T || s == ST_TT);
        exp_upg[i]  = found && smask[i] && s == ST_B;
        exp_miss[i] = !exp_hit[i];
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (exp_miss[i]) begin
        idx = -1;
        for (int k = 0; k < lines.size(); k++) if (lines[k] == addr[i][63:6]) idx = k;
        if (idx < 0) begin
          lines.push_back(addr[i][63:6]);
          masks.push_back(NL'(1) << i);
        end else begin
          masks[idx] = masks[idx] | (NL'(1) << i);
        end
      end
    end
    for (int k = 0; k < lines.size(); k++) begin
      exp_q.push_back({lines[k], 6'b0});
      exp_mask_q.push_back(masks[k]);
      if ((masks[k] & smask) == '0)       exp_grow_q.push_back(G_NTOB);
      else if ((masks[k] & exp_upg) != '0) exp_grow_q.push_back(G_BTOT);
      else                                 exp_grow_q.push_back(G_NTOT);
    end
  endtask

  // Driver tasks
  task automatic apply_inputs();
    for (int i = 0; i < NL; i++) lane_addr[i*64 +: 64] = addr[i];
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) begin
        bank_tag_way[(b*NW + w)*TW +: TW] = tg[b][w];
        bank_state_way[(b*NW + w)*2 +: 2] = st[b][w];
      end
    lane_valid = vmask;
    lane_store = smask;
  endtask

  task automatic clear_cache();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) begin
        tg[b][w] = '0;
        st[b][w] = ST_N;
      end
  endtask

  task automatic issue_and_check_rsp();
    @(negedge clk);
    apply_inputs();
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid      = 1'b0;
    lane_addr      = ~lane_addr;
    bank_tag_way   = ~bank_tag_way;
    bank_state_way = ~bank_state_way;
    lane_valid     = ~lane_valid;
    lane_store     = ~lane_store;
    check("rsp_valid", rsp_valid, 1);
    check("lane_hit", lane_hit, exp_hit);
    check("lane_miss", lane_miss, exp_miss);
    check("lane_upgrade", lane_upgrade, exp_upg);
    check("lane_hit_way", lane_hit_way, exp_way_bus);
    check("lane_state", lane_state, exp_state_bus);
    check("lookup_ready", req_ready, 0);
    check("lookup_busy", busy, 1);
    check("lookup_miss_valid", miss_valid, 0);
  endtask

  task automatic drain_and_check(input int stall_max);
    logic [63:0]   a;
    logic [NL-1:0] m;
    logic [1:0]    g;
    int            stall;
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      m = exp_mask_q.pop_front();
      g = exp_grow_q.pop_front();
      stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, stall_max));
      for (int c = 0; c <= stall; c++) begin
        @(negedge clk);
        check("miss_valid", miss_valid, 1);
        check("miss_addr", miss_addr, a);
        check("miss_mask", miss_lane_mask, m);
        check("miss_grow", miss_grow, g);
        check("drain_ready", req_ready, 0);
        check("drain_rsp_valid", rsp_valid, 0);
        miss_ready = (c == stall);
      end
    end
    @(negedge clk);
    miss_ready = 1'b0;
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_miss_valid", miss_valid, 0);
    check("idle_rsp_valid", rsp_valid, 0);
  endtask

  task automatic run_op(input int stall_max);
    model_op();
    issue_and_check_rsp();
    drain_and_check(stall_max);
  endtask

  task automatic rand_op();
    logic [57:0] pool [4];
    logic [63:0] r;
    for (int p = 0; p < 4; p++) begin
      r = {$urandom, $urandom};
      pool[p] = r[57:0];
    end
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) begin
        r = {$urandom, $urandom};
        tg[b][w] = ($urandom_range(0, 3) < 2) ? pool[$urandom_range(0, 3)][57:5] : r[TW-1:0];
        st[b][w] = 2'($urandom_range(0, 3));
      end
    for (int i = 0; i < NL; i++) addr[i] = {pool[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
    vmask = NL'($urandom);
    smask = NL'($urandom);
    run_op(3);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; miss_ready = 1'b0;
    lane_addr = '0; lane_valid = '0; lane_store = '0;
    bank_tag_way = '0; bank_state_way = '0;
    clear_cache();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_miss_valid", miss_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lane_hit", lane_hit, 0);
    check("rst_miss_addr", miss_addr, 0);

    // Empty cache, single load miss
    for (int i = 0; i < NL; i++) addr[i] = 64'h1000 + 64'(i * 8);
    vmask = 8'h01; smask = 8'h00;
    run_op(2);

    // Bank 0 way 5 holds line 0x1000 in B: load hits, store upgrades
    tg[0][5] = 53'h2; st[0][5] = ST_B;
    run_op(0);
    smask = 8'h01;
    run_op(1);

    // Unit stride stores, bank i way i in TT
    clear_cache();
    for (int i = 0; i < NL; i++) begin
      addr[i] = 64'h2000 + 64'(i * 8);
      tg[i][i] = 53'h4;
      st[i][i] = ST_TT;
    end
    vmask = 8'hFF; smask = 8'hFF;
    run_op(0);

    // Two lines of misses, lane 5 store, three stall cycles per request
    clear_cache();
    for (int i = 0; i < 4; i++) addr[i] = 64'h3000 + 64'(i * 8);
    for (int i = 4; i < NL; i++) addr[i] = 64'h4000 + 64'(i * 8);
    vmask = 8'hFF; smask = 8'h20;
    force_stall = 3;
    run_op(0);
    force_stall = -1;

    // Only lane 0 valid and hitting; other lanes point at absent lines
    tg[0][5] = 53'h2; st[0][5] = ST_B;
    addr[0] = 64'h1000;
    for (int i = 1; i < NL; i++) addr[i] = 64'h9000 + 64'(i * 64);
    vmask = 8'h01; smask = 8'h00;
    run_op(0);

    // Reset while a request is outstanding
    clear_cache();
    for (int i = 0; i < NL; i++) addr[i] = 64'h5000 + 64'(i * 8);
    vmask = 8'hFF; smask = 8'h00;
    model_op();
    issue_and_check_rsp();
    @(negedge clk);
    check("pre_rst_miss_valid", miss_valid, 1);
    miss_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_miss_valid", miss_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    exp_q.delete(); exp_mask_q.delete(); exp_grow_q.delete();
    run_op(2);

    for (int n = 0; n < 200; n++) rand_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
